iir_out_capture: RTL and testbench

- Downstream stage of the IIR filter top; consumes its data_out/data_out_valid stream.
- Discards the first SKIP valid samples (pipeline fill latency), captures exactly FRAME_LEN aligned samples into a synchronous FIFO, and serves them to a ready/valid consumer (DMA/UART/host bridge).
- Signals end of frame and a sticky overflow flag.

---
 rtl/iir_pkg.sv | 20 ++
 rtl/iir_sync_fifo.sv | 65 ++++++
 rtl/iir_out_capture.sv | 146 ++++++++++++++
 tb/tb_iir_out_capture.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
// Shared definitions for the IIR output-capture slice: FSM state encoding,
// default sample width and a counter-width helper.
package iir_pkg;

    localparam int unsigned DATA_W_DEF = 24;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SKIP    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Width in bits needed to hold values 0..n-1, never less than one bit.
    function automatic int unsigned clog2w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/iir_sync_fifo.sv
// Synchronous first-word-fall-through FIFO. DEPTH must be a power of two so
// the pointers wrap naturally. data_o reads 0 while the FIFO is empty.
module iir_sync_fifo
    import iir_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        data_i,
    input  logic                     pop_i,
    output logic [DATA_W-1:0]        data_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned AW = clog2w(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              do_push, do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LW'(DEPTH));
    assign level_o = level_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // A push at full is accepted only when a pop frees the slot this cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Next-state pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        level_d = level_q + LW'(do_push) - LW'(do_pop);
    end

    // Pointer and level registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/iir_out_capture.sv
// Frame capture stage behind the IIR filter: drops SKIP leading valid samples,
// buffers FRAME_LEN samples in a FWFT FIFO for a ready/valid consumer, pulses
// frame_done at the end and flags dropped samples in a sticky overflow bit.
// Optional macro IIR_CAPTURE_PEAK_EN adds peak_abs (max |sample| pushed).
module iir_out_capture
    import iir_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned SKIP      = 61,
    parameter int unsigned FRAME_LEN = 2048
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   in_valid,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   overflow
`ifdef IIR_CAPTURE_PEAK_EN
    ,
    output logic [DATA_W-1:0]      peak_abs
`endif
);

    localparam int unsigned SKW = clog2w(SKIP + 1);
    localparam int unsigned CPW = clog2w(FRAME_LEN + 1);
    localparam logic [SKW-1:0] SKIP_LAST = SKW'((SKIP > 0) ? SKIP - 1 : 0);
    localparam logic [CPW-1:0] CAP_LAST  = CPW'(FRAME_LEN - 1);

    state_t         state_q, state_d;
    logic [SKW-1:0] skip_cnt_q, skip_cnt_d;
    logic [CPW-1:0] cap_cnt_q, cap_cnt_d;
    logic           ovf_q, ovf_d;

    logic push, pop, fifo_full, fifo_empty;

    assign out_valid  = ~fifo_empty;
    assign pop        = out_valid & out_ready;
    assign push       = (state_q == ST_CAPTURE) & in_valid & (~fifo_full | pop);
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = (state_q == ST_DONE);
    assign overflow   = ovf_q;

    iir_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (push),
        .data_i  (in_data),
        .pop_i   (pop),
        .data_o  (out_data),
        .level_o (level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Frame sequencing: skip, capture, drain, then a one-cycle done state.
    always_comb begin
        state_d    = state_q;
        skip_cnt_d = skip_cnt_q;
        cap_cnt_d  = cap_cnt_q;
        ovf_d      = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    skip_cnt_d = '0;
                    cap_cnt_d  = '0;
                    ovf_d      = 1'b0;
                    state_d    = (SKIP > 0) ? ST_SKIP : ST_CAPTURE;
                end
            end
            ST_SKIP: begin
                if (in_valid) begin
                    skip_cnt_d = skip_cnt_q + 1'b1;
                    if (skip_cnt_q == SKIP_LAST) state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (in_valid) begin
                    cap_cnt_d = cap_cnt_q + 1'b1;
                    if (!push) ovf_d = 1'b1;
                    if (cap_cnt_q == CAP_LAST) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counter and overflow registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            skip_cnt_q <= '0;
            cap_cnt_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            skip_cnt_q <= skip_cnt_d;
            cap_cnt_q  <= cap_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

`ifdef IIR_CAPTURE_PEAK_EN
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};

    logic [DATA_W-1:0] abs_in;
    logic [DATA_W-1:0] peak_q, peak_d;

    assign peak_abs = peak_q;

    // Magnitude of the incoming sample; the most negative code saturates.
    always_comb begin
        if (!in_data[DATA_W-1])      abs_in = in_data;
        else if (in_data == MOST_NEG) abs_in = MOST_POS;
        else                          abs_in = ~in_data + 1'b1;
    end

    // Running peak over pushed samples, cleared when a frame starts.
    always_comb begin
        peak_d = peak_q;
        if ((state_q == ST_IDLE) && start)  peak_d = '0;
        else if (push && (abs_in > peak_q)) peak_d = abs_in;
    end

    // Peak register.
    always_ff @(posedge clk) begin
        if (!rst_n) peak_q <= '0;
        else        peak_q <= peak_d;
    end
`endif

endmodule

// File: tb/tb_iir_out_capture.sv
// Self-checking bench for iir_out_capture: three instances with different
// SKIP/FRAME_LEN/DEPTH, table-driven frames, hand-written corner sequences
// and a randomized run against a queue-based reference model.
module tb_iir_out_capture;

    typedef struct {
        logic        iv;
        logic [23:0] din;
        logic        has_exp;
        logic [23:0] dexp;
    } vec_t;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [3];
    logic        start [3];
    logic        iv    [3];
    logic [23:0] id    [3];
    logic        ordy  [3];
    logic        ov    [3];
    logic [23:0] od    [3];
    logic        bz    [3];
    logic        fd    [3];
    logic        of    [3];
    logic [4:0]  lvl_a, lvl_b;
    logic [2:0]  lvl_c;
`ifdef IIR_CAPTURE_PEAK_EN
    logic [23:0] pk    [3];
`endif

    int checks = 0;
    int errors = 0;
    int fdcnt [3];
    logic [23:0] got0 [$];
    logic [23:0] got1 [$];
    logic [23:0] got2 [$];

    iir_out_capture #(.DATA_W(24), .DEPTH(16), .SKIP(3), .FRAME_LEN(8)) u_a (
        .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .in_valid(iv[0]), .in_data(id[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .level(lvl_a),
        .busy(bz[0]), .frame_done(fd[0]), .overflow(of[0])
`ifdef IIR_CAPTURE_PEAK_EN
        , .peak_abs(pk[0])
`endif
    );

    iir_out_capture #(.DATA_W(24), .DEPTH(16), .SKIP(0), .FRAME_LEN(4)) u_b (
        .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .in_valid(iv[1]), .in_data(id[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .level(lvl_b),
        .busy(bz[1]), .frame_done(fd[1]), .overflow(of[1])
`ifdef IIR_CAPTURE_PEAK_EN
        , .peak_abs(pk[1])
`endif
    );

    iir_out_capture #(.DATA_W(24), .DEPTH(4), .SKIP(1), .FRAME_LEN(6)) u_c (
        .clk(clk), .rst_n(rst_n[2]), .start(start[2]), .in_valid(iv[2]), .in_data(id[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]), .level(lvl_c),
        .busy(bz[2]), .frame_done(fd[2]), .overflow(of[2])
`ifdef IIR_CAPTURE_PEAK_EN
        , .peak_abs(pk[2])
`endif
    );

    function automatic logic [4:0] get_level(input int k);
        case (k)
            0:       return lvl_a;
            1:       return lvl_b;
            default: return {2'b00, lvl_c};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    // Record what the consumer takes this cycle, then advance one clock.
    task automatic tick();
        if (ov[0] && ordy[0]) got0.push_back(od[0]);
        if (ov[1] && ordy[1]) got1.push_back(od[1]);
        if (ov[2] && ordy[2]) got2.push_back(od[2]);
        for (int k = 0; k < 3; k++) if (fd[k]) fdcnt[k]++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_idle(input int k, input int maxc, input string nm);
        int n = 0;
        while (bz[k] && n < maxc) begin
            tick();
            n++;
        end
        chk(nm, bz[k], 1'b0);
    endtask

    // Full frame on instance A (SKIP=3, FRAME_LEN=8); the sample coincident
    // with start must be ignored.
    task automatic frame_a(input logic [23:0] base, input string tag);
        vec_t tbl [11];
        for (int i = 0; i < 11; i++) begin
            tbl[i].iv      = 1'b1;
            tbl[i].din     = base + 24'(i);
            tbl[i].has_exp = (i >= 3);
            tbl[i].dexp    = base + 24'(i);
        end
        got0.delete();
        fdcnt[0] = 0;
        ordy[0]  = 1'b1;
        start[0] = 1'b1; iv[0] = 1'b1; id[0] = 24'h000099;
        tick();
        start[0] = 1'b0;
        chk({tag, "_busy_after_start"}, bz[0], 1'b1);
        for (int i = 0; i < 11; i++) begin
            iv[0] = tbl[i].iv;
            id[0] = tbl[i].din;
            tick();
        end
        iv[0] = 1'b0; id[0] = '0;
        wait_idle(0, 40, {tag, "_idle"});
        chk({tag, "_n_out"}, got0.size(), 8);
        for (int i = 0; i < 11; i++)
            if (tbl[i].has_exp && got0.size() > 0)
                chk({tag, "_data"}, got0.pop_front(), tbl[i].dexp);
        chk({tag, "_frame_done_cnt"}, fdcnt[0], 1);
        chk({tag, "_overflow"}, of[0], 1'b0);
    endtask

    task automatic test_sign();
        logic [23:0] vals [4];
        int n = 0;
        vals[0] = 24'hFFFFFF; vals[1] = 24'h800000; vals[2] = 24'h7FFFFF; vals[3] = 24'h000001;
        got1.delete();
        fdcnt[1] = 0;
        ordy[1]  = 1'b1;
        start[1] = 1'b1; tick(); start[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            iv[1] = 1'b1; id[1] = vals[i]; tick();
            iv[1] = 1'b0; id[1] = '0;      tick();
        end
        while (!fd[1] && n < 20) begin
            tick();
            n++;
        end
        chk("t2_done_pulse", fd[1], 1'b1);
        tick();
        chk("t2_busy_after_done", bz[1], 1'b0);
        chk("t2_n_out", got1.size(), 4);
        for (int i = 0; i < 4; i++)
            if (got1.size() > 0) chk("t2_data", got1.pop_front(), vals[i]);
        chk("t2_frame_done_cnt", fdcnt[1], 1);
    endtask

    task automatic test_overflow();
        got2.delete();
        fdcnt[2] = 0;
        ordy[2]  = 1'b0;
        start[2] = 1'b1; tick(); start[2] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            iv[2] = 1'b1; id[2] = 24'h10 + 24'(i); tick();
        end
        iv[2] = 1'b0; id[2] = '0;
        chk("t3_level_sat", get_level(2), 5'd4);
        chk("t3_overflow", of[2], 1'b1);
        chk("t3_busy_drain", bz[2], 1'b1);
        chk("t3_head", od[2], 24'h11);
        ordy[2] = 1'b1;
        wait_idle(2, 30, "t3_idle");
        chk("t3_n_out", got2.size(), 4);
        for (int i = 0; i < 4; i++)
            if (got2.size() > 0) chk("t3_data", got2.pop_front(), 24'h11 + 24'(i));
        chk("t3_frame_done_cnt", fdcnt[2], 1);
        chk("t3_overflow_sticky", of[2], 1'b1);
    endtask

    task automatic test_full_pushpop();
        got2.delete();
        ordy[2]  = 1'b0;
        start[2] = 1'b1; tick(); start[2] = 1'b0;
        chk("t4_overflow_cleared", of[2], 1'b0);
        for (int i = 0; i < 5; i++) begin
            iv[2] = 1'b1; id[2] = 24'h20 + 24'(i); tick();
        end
        chk("t4_level_full", get_level(2), 5'd4);
        ordy[2] = 1'b1; iv[2] = 1'b1; id[2] = 24'h25; tick();
        ordy[2] = 1'b0; iv[2] = 1'b0;
        chk("t4_level_hold", get_level(2), 5'd4);
        chk("t4_no_overflow", of[2], 1'b0);
        ordy[2] = 1'b1; iv[2] = 1'b1; id[2] = 24'h26; tick();
        iv[2] = 1'b0; id[2] = '0;
        wait_idle(2, 30, "t4_idle");
        chk("t4_n_out", got2.size(), 6);
        for (int i = 0; i < 6; i++)
            if (got2.size() > 0) chk("t4_order", got2.pop_front(), 24'h21 + 24'(i));
        chk("t4_overflow_end", of[2], 1'b0);
    endtask

    task automatic test_reset_mid();
        ordy[0]  = 1'b0;
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            iv[0] = 1'b1; id[0] = 24'h30 + 24'(i); tick();
        end
        iv[0] = 1'b0;
        chk("t5_level_before", get_level(0), 5'd5);
        rst_n[0] = 1'b0; tick(); rst_n[0] = 1'b1;
        chk("t5_out_valid", ov[0], 1'b0);
        chk("t5_level", get_level(0), 5'd0);
        chk("t5_busy", bz[0], 1'b0);
        chk("t5_out_data", od[0], 24'h0);
        frame_a(24'h40, "t5_refill");
    endtask

    // Randomized run on instance C against a frame-level queue model.
    task automatic test_random();
        localparam int C_SKIP = 1, C_FL = 6, C_DEPTH = 4;
        int          ph = 0, cnt = 0;
        logic        movf = 1'b0;
        logic [23:0] q [$];
        rst_n[2] = 1'b0; tick(); rst_n[2] = 1'b1;
        for (int cyc = 0; cyc < 800; cyc++) begin
            int   osz;
            logic st, v, r, p_pop, p_push;
            logic [23:0] d;
            osz = q.size();
            chk("rnd_out_valid", ov[2], osz != 0);
            chk("rnd_out_data", od[2], (osz != 0) ? q[0] : 24'h0);
            chk("rnd_level", get_level(2), 5'(osz));
            chk("rnd_busy", bz[2], ph != 0);
            chk("rnd_frame_done", fd[2], ph == 4);
            chk("rnd_overflow", of[2], movf);
            st = ($urandom_range(0, 5) == 0);
            v  = ($urandom_range(0, 9) < 6);
            r  = ($urandom_range(0, 2) != 0);
            d  = 24'($urandom);
            p_pop  = (osz != 0) && r;
            p_push = (ph == 2) && v && ((osz < C_DEPTH) || p_pop);
            if (p_pop)  void'(q.pop_front());
            if (p_push) q.push_back(d);
            case (ph)
                0: if (st) begin ph = (C_SKIP > 0) ? 1 : 2; cnt = 0; movf = 1'b0; end
                1: if (v) begin cnt++; if (cnt == C_SKIP) begin ph = 2; cnt = 0; end end
                2: if (v) begin
                       if (!p_push) movf = 1'b1;
                       cnt++;
                       if (cnt == C_FL) ph = 3;
                   end
                3: if (osz == 0) ph = 4;
                default: ph = 0;
            endcase
            start[2] = st; iv[2] = v; id[2] = d; ordy[2] = r;
            tick();
        end
        start[2] = 1'b0; iv[2] = 1'b0; id[2] = '0; ordy[2] = 1'b0;
    endtask

`ifdef IIR_CAPTURE_PEAK_EN
    task automatic test_peak();
        logic [23:0] cap [8];
        cap[0] = 24'hFFFFFB; cap[1] = 24'h800000; cap[2] = 24'h000064;
        for (int i = 3; i < 8; i++) cap[i] = '0;
        ordy[0]  = 1'b1;
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin iv[0] = 1'b1; id[0] = 24'h7FFFF0; tick(); end
        for (int i = 0; i < 8; i++) begin iv[0] = 1'b1; id[0] = cap[i]; tick(); end
        iv[0] = 1'b0; id[0] = '0;
        wait_idle(0, 40, "peak_idle");
        chk("peak_value", pk[0], 24'h7FFFFF);
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        chk("peak_cleared", pk[0], 24'h0);
    endtask
`endif

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0; start[k] = 1'b0; iv[k] = 1'b0;
            id[k] = '0; ordy[k] = 1'b0; fdcnt[k] = 0;
        end
        @(negedge clk);
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("rst_out_valid", ov[k], 1'b0);
            chk("rst_level", get_level(k), 5'd0);
            chk("rst_busy", bz[k], 1'b0);
            chk("rst_frame_done", fd[k], 1'b0);
            chk("rst_overflow", of[k], 1'b0);
            chk("rst_out_data", od[k], 24'h0);
`ifdef IIR_CAPTURE_PEAK_EN
            chk("rst_peak", pk[k], 24'h0);
`endif
        end
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;

        frame_a(24'h000001, "t1");
        test_sign();
        test_overflow();
        test_full_pushpop();
        test_reset_mid();
        test_random();
`ifdef IIR_CAPTURE_PEAK_EN
        test_peak();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
